k_calc_golomb: RTL and testbench
================================

# k_calc_golomb

Computes the JPEG-LS Golomb coding parameter k from a context's occurrence count N and its accumulated error magnitude. For regular mode the magnitude is A; for run-interruption mode it is TEMP. The block sits between the context-statistics store and the Golomb encoder/decoder. The search over k is fully unrolled: every candidate shift is compared in parallel, then priority-encoded, and the result is registered.

## Interface
- N_length, 7: width of N.
- A_length, 16: width of A.
- mode_length, 2: width of mode.
- temp_length, 17: width of temp.
- k_length, 5: width of k_inc and k.
- K_MAX, 16: largest k the block can produce; candidates 0..K_MAX are unrolled.

Ports (one clock; reset is synchronous and active-high):
- clk  input  1: rising-edge clock.
- rst  input  1: synchronous active-high reset.
- N  input  N_length: context occurrence count.
- A  input  A_length: accumulated error magnitude, used in regular mode.
- mode  input  mode_length: 0 = regular, 1 = run, 2 = run interruption, 3 = reserved.
- RIType  input  1: run-interruption type.
- temp  input  temp_length: A of the run-interruption context.
- k_inc  input  k_length: minimum k, the start of the search.
- k  output  k_length: registered Golomb parameter.

## Operation
- Target T is selected by mode:
  - mode 0: T = zero-extended A.
  - mode 2: T = temp + (RIType ? (N >> 1) : 0), computed at temp_length+1 bits with no overflow.
  - mode 1 or 3: k_next = 0. Run-length k comes from the J table elsewhere.
- For each c in 0..K_MAX, form hit[c] = ((N << c) >= T) AND (c >= k_inc).
  - The shift is evaluated at N_length+K_MAX bits, so no bit is lost.
  - T is zero-extended to the same width.
- k_next is the lowest c with hit[c] = 1. If no c hits, k_next = K_MAX.
- Equivalent sequential reference: k = k_inc; while ((N << k) < T && k < K_MAX) k++.
- Boundary conditions:
  - T = 0 → k_next = min(k_inc, K_MAX).
  - N = 0 and T > 0 → K_MAX.
  - k_inc > K_MAX → K_MAX.
  - Maximum A or temp never wraps.
- All inputs are treated as unsigned. There is no handshake; a new input set may be applied every cycle.

## Timing
- Without the pipeline feature: inputs are sampled at rising edge t, and k = k_next(inputs@t) from edge t until the next edge. Latency is 1 cycle, throughput 1 per cycle.
- Reset value of k is 0.
- rst has priority over new data. If rst is asserted at edge t, k = 0 after t regardless of inputs, and any in-flight result is discarded.
- The first valid result appears at the first edge after rst deasserts at which inputs are present.
- The output holds its value only as long as inputs are held; there is no enable.

## Configuration
- K_CALC_PIPE2_EN
  - Defined: an extra register stage holds the hit[] vector (and the mode-1/3 zero flag). The priority encode happens in stage 2, so latency is 2 cycles and throughput stays 1 per cycle. rst clears both stages: k = 0, hit vector cleared.
  - Undefined: single stage, latency 1 as specified above.
  - Results are otherwise bit-identical.

## Test plan
- Regular mode: mode=0, N=4, A=20, k_inc=0 → k=3. Then N=8, A=8 → k=0.
- Run interruption: mode=2, N=6, temp=22. RIType=0 gives T=22 → k=2. RIType=1 gives T=25 → k=3.
- Boundaries, all with mode=0:
  - N=0, A=5 → k=16.
  - N=1, A=0 → k=0.
  - N=127, A=65535 → k=10.
- k_inc floor: mode=0, N=8, A=3, k_inc=2 → k=2. k_inc=20 → k=16.
- Run mode: mode=1 with any N/A → k=0.
- Reset: apply N=4, A=20, assert rst for one edge mid-stream → k=0 the next cycle. After deassert, k=3 after 1 cycle (2 with K_CALC_PIPE2_EN).

Source files
------------

// File: rtl/k_calc_golomb_if.sv
// k_calc_golomb_if: input/output bundle between the context-statistics store
// and the Golomb k calculator.
//   N       context occurrence count
//   A       accumulated error magnitude (regular mode)
//   mode    0 regular, 1 run, 2 run interruption, 3 reserved
//   RIType  run-interruption type
//   temp    A of the run-interruption context
//   k_inc   minimum k, start of the search
//   k       registered Golomb parameter
// master drives the context inputs; slave is the calculator.
interface k_calc_golomb_if #(
    parameter int unsigned N_length    = 7,
    parameter int unsigned A_length    = 16,
    parameter int unsigned mode_length = 2,
    parameter int unsigned temp_length = 17,
    parameter int unsigned k_length    = 5
);
    logic [N_length-1:0]    N;
    logic [A_length-1:0]    A;
    logic [mode_length-1:0] mode;
    logic                   RIType;
    logic [temp_length-1:0] temp;
    logic [k_length-1:0]    k_inc;
    logic [k_length-1:0]    k;

    modport master (
        output N, A, mode, RIType, temp, k_inc,
        input  k
    );

    modport slave (
        input  N, A, mode, RIType, temp, k_inc,
        output k
    );
endinterface

// File: rtl/k_calc_golomb.sv
// k_calc_golomb: JPEG-LS Golomb parameter k from N and A (regular mode) or
// TEMP (run-interruption mode). All candidate shifts 0..K_MAX are compared in
// parallel, priority-encoded to the lowest hit at or above k_inc, and
// registered.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset, clears k to 0
//   bus  k_calc_golomb_if.slave: N, A, mode, RIType, temp, k_inc in; k out
// Optional build macro K_CALC_PIPE2_EN: registers the hit vector and the
// run-mode zero flag, moving the priority encode to a second stage
// (latency 2 instead of 1, throughput unchanged).
module k_calc_golomb #(
    parameter int unsigned N_length    = 7,
    parameter int unsigned A_length    = 16,
    parameter int unsigned mode_length = 2,
    parameter int unsigned temp_length = 17,
    parameter int unsigned k_length    = 5,
    parameter int unsigned K_MAX       = 16
) (
    input  logic           clk,
    input  logic           rst,
    k_calc_golomb_if.slave bus
);
    // Shift width large enough that N << K_MAX loses nothing.
    localparam int unsigned ShW  = N_length + K_MAX;
    localparam int unsigned SumW = temp_length + 1;
    localparam int unsigned HitW = K_MAX + 1;

    logic [SumW-1:0]     ri_sum;
    logic [ShW-1:0]      target;
    logic [HitW-1:0]     hit;
    logic                run_zero;
    logic [k_length-1:0] k_d, k_q;

    // Lowest hit wins; no hit saturates to K_MAX; run/reserved modes force 0.
    function automatic logic [k_length-1:0] prio_enc(input logic [HitW-1:0] h,
                                                     input logic            z);
        logic [k_length-1:0] r;
        r = k_length'(K_MAX);
        for (int c = int'(K_MAX); c >= 0; c--) begin
            if (h[c]) r = k_length'(c);
        end
        if (z) r = '0;
        return r;
    endfunction

    // Run-interruption target; one extra bit so temp + N/2 never wraps.
    always_comb begin
        ri_sum = SumW'(bus.temp);
        if (bus.RIType) ri_sum = ri_sum + SumW'(bus.N >> 1);
    end

    always_comb begin
        target   = '0;
        run_zero = 1'b0;
        case (bus.mode)
            mode_length'(0): target   = ShW'(bus.A);
            mode_length'(2): target   = ShW'(ri_sum);
            default:         run_zero = 1'b1;
        endcase
    end

    always_comb begin
        hit = '0;
        for (int unsigned c = 0; c < HitW; c++) begin
            hit[c] = ((ShW'(bus.N) << c) >= target) && (c >= 32'(bus.k_inc));
        end
    end

`ifdef K_CALC_PIPE2_EN
    logic [HitW-1:0] hit_d, hit_q;
    logic            zero_d, zero_q;

    always_comb begin
        hit_d  = hit;
        zero_d = run_zero;
        k_d    = prio_enc(hit_q, zero_q);
    end

    // The zero flag resets high so the cleared stage drains as k = 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_q  <= '0;
            zero_q <= 1'b1;
            k_q    <= '0;
        end else begin
            hit_q  <= hit_d;
            zero_q <= zero_d;
            k_q    <= k_d;
        end
    end
`else
    always_comb begin
        k_d = prio_enc(hit, run_zero);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            k_q <= '0;
        end else begin
            k_q <= k_d;
        end
    end
`endif

    assign bus.k = k_q;
endmodule

// File: tb/tb_k_calc_golomb.sv
// tb_k_calc_golomb: directed plus randomized check of k_calc_golomb against a
// plain-arithmetic reference (the sequential k search), including reset
// mid-stream and pipeline latency when K_CALC_PIPE2_EN is defined.
module tb_k_calc_golomb;
    localparam int unsigned K_MAX = 16;
`ifdef K_CALC_PIPE2_EN
    localparam int unsigned LAT = 2;
`else
    localparam int unsigned LAT = 1;
`endif

    logic clk;
    logic rst;
    k_calc_golomb_if bus ();

    k_calc_golomb dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_vec;
    int unsigned n_err;
    int unsigned exp_k;
    int unsigned exp_stage;

    task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: k=%0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int unsigned ref_k(input int unsigned n, input int unsigned a,
                                          input int unsigned m, input int unsigned ri,
                                          input int unsigned tp, input int unsigned ki);
        longint unsigned t;
        int unsigned     k;
        if (m == 1 || m == 3) return 0;
        t = (m == 0) ? 64'(a) : 64'(tp) + 64'((ri != 0) ? n / 2 : 0);
        k = ki;
        while (k < K_MAX && ((64'(n) << k) < t)) k++;
        return (k > K_MAX) ? K_MAX : k;
    endfunction

    // Apply one input set for one edge, advance the model, compare after the edge.
    task automatic step(input bit r, input int unsigned n, input int unsigned a,
                        input int unsigned m, input int unsigned ri,
                        input int unsigned tp, input int unsigned ki, input string tag);
        int unsigned f;
        rst        = r;
        bus.N      = 7'(n);
        bus.A      = 16'(a);
        bus.mode   = 2'(m);
        bus.RIType = 1'(ri);
        bus.temp   = 17'(tp);
        bus.k_inc  = 5'(ki);
        f = ref_k(n, a, m, ri, tp, ki);
        @(posedge clk);
        #1;
        if (r) begin
            exp_stage = 0;
            exp_k     = 0;
        end else if (LAT == 2) begin
            exp_k     = exp_stage;
            exp_stage = f;
        end else begin
            exp_k = f;
        end
        check(tag, bus.k, 5'(exp_k));
    endtask

    function automatic int unsigned rnd_mag(input int unsigned bits);
        int unsigned sel;
        sel = $urandom_range(0, 9);
        if (sel == 0) return 0;
        if (sel == 1) return (1 << bits) - 1;
        return $urandom & ((1 << $urandom_range(1, bits)) - 1);
    endfunction

    initial begin
        n_vec     = 0;
        n_err     = 0;
        exp_k     = 0;
        exp_stage = 0;
        rst       = 1'b1;
        #2;

        step(1, 0, 0, 0, 0, 0, 0, "reset0");
        step(1, 4, 20, 0, 0, 0, 0, "reset1");

        // Directed cases; each held two cycles so the value is seen at either latency.
        for (int i = 0; i < 2; i++) step(0, 4, 20, 0, 0, 0, 0, "reg_n4_a20");
        for (int i = 0; i < 2; i++) step(0, 8, 8, 0, 0, 0, 0, "reg_n8_a8");
        for (int i = 0; i < 2; i++) step(0, 6, 0, 2, 0, 22, 0, "ri_t22");
        for (int i = 0; i < 2; i++) step(0, 6, 0, 2, 1, 22, 0, "ri_t25");
        for (int i = 0; i < 2; i++) step(0, 0, 5, 0, 0, 0, 0, "n0_a5");
        for (int i = 0; i < 2; i++) step(0, 1, 0, 0, 0, 0, 0, "n1_a0");
        for (int i = 0; i < 2; i++) step(0, 127, 65535, 0, 0, 0, 0, "nmax_amax");
        for (int i = 0; i < 2; i++) step(0, 8, 3, 0, 0, 0, 2, "kinc2");
        for (int i = 0; i < 2; i++) step(0, 8, 3, 0, 0, 0, 20, "kinc20");
        for (int i = 0; i < 2; i++) step(0, 127, 0, 2, 1, 131071, 0, "temp_max");
        for (int i = 0; i < 2; i++) step(0, 0, 0, 0, 0, 0, 5, "t0_kinc5");
        for (int i = 0; i < 2; i++) step(0, 37, 999, 1, 1, 5000, 3, "run_mode");
        for (int i = 0; i < 2; i++) step(0, 37, 999, 3, 0, 5000, 3, "reserved");

        // Reset mid-stream, then recovery.
        for (int i = 0; i < 3; i++) step(0, 4, 20, 0, 0, 0, 0, "pre_rst");
        step(1, 4, 20, 0, 0, 0, 0, "mid_rst");
        for (int i = 0; i < 3; i++) step(0, 4, 20, 0, 0, 0, 0, "post_rst");

        // Randomized stream with occasional resets.
        for (int i = 0; i < 600; i++) begin
            int unsigned n;
            int unsigned ki;
            n  = ($urandom_range(0, 9) == 0) ? 0 :
                 ($urandom_range(0, 9) == 0) ? 127 : $urandom_range(0, 127);
            ki = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 6);
            step(($urandom_range(0, 49) == 0), n, rnd_mag(16), $urandom_range(0, 3),
                 $urandom_range(0, 1), rnd_mag(17), ki, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
